// File: rtl/frame_sync_stage.sv
// Registered Avalon-ST stage ahead of the brightness filter: 2-entry skid buffer,
// per-frame latching of the audio-derived flags, stray-beat discard and frame-length checking.
module frame_sync_stage #(
    parameter int WIDTH = 12,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sop_in,
    input  logic             eop_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [1:0]       freq_flag_in,
    input  logic             use_flag_in,
    output logic [WIDTH-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [1:0]       freq_flag_out,
    output logic             use_flag_out,
    output logic             frame_error,
    output logic [15:0]      frame_count
);

    localparam logic [16:0] FRAME_LEN = 17'(IMG_W * IMG_H);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
        logic [1:0]       freq;
        logic             use_en;
    } beat_t;

    beat_t       mem_q [2];
    beat_t       push_beat;
    beat_t       head;
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        ready_q;
    state_t      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [1:0]  latch_freq_q, latch_freq_d;
    logic        latch_use_q, latch_use_d;
    logic        err_q, err_d;
    logic [15:0] fcount_q, fcount_d;
    logic [1:0]  hold_freq_q;
    logic        hold_use_q;
    logic        accept, push, pop, close;
    logic [16:0] close_len;

    assign accept = valid_in && ready_q;
    assign pop    = (count_q != 2'd0) && ready_in;

    // The sop beat carries the live flags; later beats of the frame carry the latched copy.
    always_comb begin
        push_beat.data   = data_in;
        push_beat.sop    = sop_in;
        push_beat.eop    = eop_in;
        push_beat.freq   = sop_in ? freq_flag_in : latch_freq_q;
        push_beat.use_en = sop_in ? use_flag_in : latch_use_q;
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_freq_d = latch_freq_q;
        latch_use_d  = latch_use_q;
        err_d        = 1'b0;
        fcount_d     = fcount_q;
        push         = 1'b0;
        close        = 1'b0;
        close_len    = '0;
        if (accept) begin
            if (sop_in) begin
                push         = 1'b1;
                latch_freq_d = freq_flag_in;
                latch_use_d  = use_flag_in;
                cnt_d        = 17'd1;
                if (state_q == IN_FRAME) err_d = 1'b1;
                if (eop_in) begin
                    close     = 1'b1;
                    close_len = 17'd1;
                    state_d   = IDLE;
                end else begin
                    state_d = IN_FRAME;
                end
            end else if (state_q == IN_FRAME) begin
                push  = 1'b1;
                cnt_d = cnt_q + 17'd1;
                if (eop_in) begin
                    close     = 1'b1;
                    close_len = cnt_q + 17'd1;
                    state_d   = IDLE;
                end
            end
        end
        if (close) begin
            fcount_d = fcount_q + 16'd1;
            if (close_len != FRAME_LEN) err_d = 1'b1;
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= 2'd0;
            ready_q      <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            latch_freq_q <= 2'd0;
            latch_use_q  <= 1'b0;
            err_q        <= 1'b0;
            fcount_q     <= 16'd0;
            hold_freq_q  <= 2'd0;
            hold_use_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            ready_q      <= (count_d != 2'd2);
            wr_ptr_q     <= wr_ptr_q ^ push;
            rd_ptr_q     <= rd_ptr_q ^ pop;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            latch_freq_q <= latch_freq_d;
            latch_use_q  <= latch_use_d;
            err_q        <= err_d;
            fcount_q     <= fcount_d;
            if (count_q != 2'd0) begin
                hold_freq_q <= head.freq;
                hold_use_q  <= head.use_en;
            end
        end
    end

    // NOTE: the storage array is not reset; the occupancy count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_beat;
    end

    assign head          = mem_q[rd_ptr_q];
    assign valid_out     = (count_q != 2'd0);
    assign ready_out     = ready_q;
    assign data_out      = valid_out ? head.data : '0;
    assign sop_out       = valid_out && head.sop;
    assign eop_out       = valid_out && head.eop;
    assign freq_flag_out = valid_out ? head.freq : hold_freq_q;
    assign use_flag_out  = valid_out ? head.use_en : hold_use_q;
    assign frame_error   = err_q;
    assign frame_count   = fcount_q;

endmodule

// File: tb/tb_frame_sync_stage.sv
// Directed and randomized bench for frame_sync_stage (10x10 frames) against a
// frame-level reference model with an expected-beat queue.
module tb_frame_sync_stage;

    localparam int WIDTH = 12;
    localparam int IW    = 10;
    localparam int IH    = 10;
    localparam int FLEN  = IW * IH;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             sop_in, eop_in, valid_in;
    logic             ready_out;
    logic [1:0]       freq_flag_in;
    logic             use_flag_in;
    logic [WIDTH-1:0] data_out;
    logic             sop_out, eop_out, valid_out;
    logic             ready_in;
    logic [1:0]       freq_flag_out;
    logic             use_flag_out;
    logic             frame_error;
    logic [15:0]      frame_count;

    always #5 clk = ~clk;

    frame_sync_stage #(.WIDTH(WIDTH), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .sop_in       (sop_in),
        .eop_in       (eop_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .freq_flag_in (freq_flag_in),
        .use_flag_in  (use_flag_in),
        .data_out     (data_out),
        .sop_out      (sop_out),
        .eop_out      (eop_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .freq_flag_out(freq_flag_out),
        .use_flag_out (use_flag_out),
        .frame_error  (frame_error),
        .frame_count  (frame_count)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             s;
        logic             e;
        logic [1:0]       f;
        logic             u;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    bit          m_in_frame;
    int          m_len;
    logic [1:0]  m_lfreq, m_hfreq;
    logic        m_luse, m_huse;
    logic        m_err, m_rdy;
    logic [15:0] m_fc;
    bit          last_acc;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pre_checks();
        check("ready_out", 32'(ready_out), 32'(m_rdy));
        check("valid_out", 32'(valid_out), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("data_out", 32'(data_out), 32'(exp_q[0].d));
            check("sop_out", 32'(sop_out), 32'(exp_q[0].s));
            check("eop_out", 32'(eop_out), 32'(exp_q[0].e));
            check("freq_out", 32'(freq_flag_out), 32'(exp_q[0].f));
            check("use_out", 32'(use_flag_out), 32'(exp_q[0].u));
            m_hfreq = exp_q[0].f;
            m_huse  = exp_q[0].u;
        end else begin
            check("data_empty", 32'(data_out), 32'd0);
            check("sop_empty", 32'(sop_out), 32'd0);
            check("eop_empty", 32'(eop_out), 32'd0);
            check("freq_hold", 32'(freq_flag_out), 32'(m_hfreq));
            check("use_hold", 32'(use_flag_out), 32'(m_huse));
        end
    endtask

    task automatic close_frame();
        if (m_len != FLEN) m_err = 1'b1;
        m_fc       = m_fc + 16'd1;
        m_in_frame = 1'b0;
    endtask

    // One clock: check outputs, advance the model on the handshakes of this edge, check registered status.
    task automatic cycle();
        bit   acc, pop;
        exp_t e;
        if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
        pre_checks();
        acc   = valid_in && m_rdy;
        pop   = (exp_q.size() != 0) && ready_in;
        m_err = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (acc && !reset) begin
            if (sop_in) begin
                if (m_in_frame) m_err = 1'b1;
                m_lfreq = freq_flag_in;
                m_luse  = use_flag_in;
                e = '{d: data_in, s: 1'b1, e: eop_in, f: freq_flag_in, u: use_flag_in};
                exp_q.push_back(e);
                m_len      = 1;
                m_in_frame = 1'b1;
                if (eop_in) close_frame();
            end else if (m_in_frame) begin
                m_len++;
                e = '{d: data_in, s: 1'b0, e: eop_in, f: m_lfreq, u: m_luse};
                exp_q.push_back(e);
                if (eop_in) close_frame();
            end
        end
        if (reset) begin
            exp_q.delete();
            m_in_frame = 1'b0;
            m_len      = 0;
            m_lfreq    = 2'd0;
            m_luse     = 1'b0;
            m_hfreq    = 2'd0;
            m_huse     = 1'b0;
            m_fc       = 16'd0;
            m_err      = 1'b0;
        end
        last_acc = acc && !reset;
        @(posedge clk);
        #1;
        m_rdy = !reset && (exp_q.size() < 2);
        check("frame_error", 32'(frame_error), 32'(m_err));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        if (frame_error) pulses++;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic s, input logic e,
                             input logic [1:0] f, input logic u);
        int n = 0;
        data_in      = d;
        sop_in       = s;
        eop_in       = e;
        freq_flag_in = f;
        use_flag_in  = u;
        valid_in     = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 200);
        check("accept_timeout", 32'(last_acc), 32'd1);
        valid_in = 1'b0;
    endtask

    // Flags f/u go with the sop beat; af/au are driven on all later beats.
    task automatic send_frame(input int len, input logic [1:0] f, input logic u,
                              input logic [1:0] af, input logic au, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_beat(12'($urandom), i == 0, i == len - 1,
                      (i == 0) ? f : af, (i == 0) ? u : au);
        end
    endtask

    initial begin
        int          p0;
        logic [15:0] fc0;
        int          kind;
        reset = 1'b1; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        data_in = '0; freq_flag_in = 2'd0; use_flag_in = 1'b0; ready_in = 1'b1;
        @(posedge clk);
        #1;
        m_in_frame = 1'b0; m_len = 0; m_lfreq = 2'd0; m_luse = 1'b0;
        m_hfreq = 2'd0; m_huse = 1'b0; m_err = 1'b0; m_rdy = 1'b0; m_fc = 16'd0;
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_sop", 32'(sop_out), 32'd0);
        check("rst_eop", 32'(eop_out), 32'd0);
        check("rst_freq", 32'(freq_flag_out), 32'd0);
        check("rst_use", 32'(use_flag_out), 32'd0);
        check("rst_err", 32'(frame_error), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        idle(1);
        check("ready_after_rst", 32'(ready_out), 32'd1);

        // Full frame at one beat per cycle.
        send_frame(FLEN, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0);
        idle(3);
        check("full_fc", 32'(frame_count), 32'd1);
        check("full_no_err", 32'(pulses), 32'd0);

        // Mid-frame flag change is ignored until the next sop.
        send_frame(FLEN, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0);
        send_frame(FLEN, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0);
        idle(3);
        check("flag_hold_last", 32'(freq_flag_out), 32'd3);

        // Backpressure: two beats fill the buffer, head holds.
        ready_in = 1'b0;
        send_beat(12'h001, 1'b1, 1'b0, 2'd1, 1'b1);
        send_beat(12'h002, 1'b0, 1'b0, 2'd0, 1'b0);
        check("bp_ready_low", 32'(ready_out), 32'd0);
        check("bp_head", 32'(data_out), 32'h001);
        idle(1);
        check("bp_head_stable", 32'(data_out), 32'h001);
        ready_in = 1'b1;
        send_beat(12'h003, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 3; i < FLEN; i++)
            send_beat(12'($urandom), 1'b0, i == FLEN - 1, 2'd2, 1'b0);
        idle(3);

        // Stray beats outside a frame are dropped silently.
        p0 = pulses;
        fc0 = m_fc;
        for (int i = 0; i < 3; i++) send_beat(12'hAAA, 1'b0, 1'b0, 2'd1, 1'b1);
        idle(1);
        check("stray_drop", 32'(valid_out), 32'd0);
        send_frame(FLEN, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0);
        idle(3);
        check("stray_no_err", 32'(pulses - p0), 32'd0);
        check("stray_then_fc", 32'(frame_count), 32'(fc0 + 16'd1));

        // Exact and short frame length.
        p0 = pulses;
        fc0 = m_fc;
        send_frame(FLEN, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(3);
        check("len_exact_err", 32'(pulses - p0), 32'd0);
        check("len_exact_fc", 32'(frame_count), 32'(fc0 + 16'd1));
        send_frame(FLEN - 1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(3);
        check("len_short_err", 32'(pulses - p0), 32'd1);
        check("len_short_fc", 32'(frame_count), 32'(fc0 + 16'd2));

        // A new sop before eop is an error; the new frame still counts.
        p0 = pulses;
        fc0 = m_fc;
        for (int i = 0; i < 50; i++) send_beat(12'($urandom), i == 0, 1'b0, 2'd1, 1'b0);
        send_frame(FLEN, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0);
        idle(3);
        check("dbl_sop_err", 32'(pulses - p0), 32'd1);
        check("dbl_sop_fc", 32'(frame_count), 32'(fc0 + 16'd1));

        // Reset with two beats buffered.
        ready_in = 1'b0;
        send_beat(12'h055, 1'b1, 1'b0, 2'd3, 1'b1);
        send_beat(12'h066, 1'b0, 1'b0, 2'd3, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_mid_valid", 32'(valid_out), 32'd0);
        check("rst_mid_fc", 32'(frame_count), 32'd0);
        ready_in = 1'b1;
        p0 = pulses;
        idle(1);
        send_beat(12'h077, 1'b0, 1'b1, 2'd1, 1'b0);
        idle(1);
        check("rst_needs_sop", 32'(valid_out), 32'd0);
        send_frame(FLEN, 2'd1, 1'b0, 2'd2, 1'b1, 1'b0);
        idle(3);
        check("rst_next_frame_fc", 32'(frame_count), 32'd1);
        check("rst_no_err", 32'(pulses - p0), 32'd0);

        // Randomized traffic with random backpressure and gaps.
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6)
                send_frame(FLEN, 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1);
            else if (kind == 6)
                send_frame(int'($urandom_range(FLEN - 5, FLEN + 5)), 2'($urandom), 1'($urandom),
                           2'($urandom), 1'($urandom), 1'b1);
            else if (kind == 7)
                for (int i = 0; i < 3; i++) send_beat(12'($urandom), 1'b0, 1'($urandom), 2'($urandom), 1'b0);
            else if (kind == 8)
                for (int i = 0; i < 20; i++) send_beat(12'($urandom), i == 0, 1'b0, 2'($urandom), 1'($urandom));
            else
                send_beat(12'($urandom), 1'b1, 1'b1, 2'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        ready_in   = 1'b1;
        idle(5);
        check("final_drained", 32'(valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sync_stage.md
# frame_sync_stage

Registered Avalon-ST stage directly upstream of the brightness filter in the 12-bit RGB444 video path. It cuts the combinational ready/valid path with a 2-entry skid buffer. It latches the audio-derived `freq_flag` and `use_flag` at start of frame, so brightness never changes mid-frame. It discards beats outside a frame and reports malformed frames.

## Interface
Parameters:
- `WIDTH`, 12: pixel data width (RGB444).
- `IMG_W`, 320: pixels per line.
- `IMG_H`, 240: lines per frame. Expected beats per frame is `IMG_W*IMG_H`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  sink pixel.
- `sop_in`  in  1  sink start of packet.
- `eop_in`  in  1  sink end of packet.
- `valid_in`  in  1  sink valid.
- `ready_out`  out  1  backpressure to upstream. Registered.
- `freq_flag_in`  in  2  live brightness level.
- `use_flag_in`  in  1  live filter enable.
- `data_out`  out  WIDTH  source pixel.
- `sop_out`  out  1  source start of packet.
- `eop_out`  out  1  source end of packet.
- `valid_out`  out  1  source valid.
- `ready_in`  in  1  backpressure from downstream.
- `freq_flag_out`  out  2  frame-stable level, aligned to the head beat.
- `use_flag_out`  out  1  frame-stable enable, aligned to the head beat.
- `frame_error`  out  1  one-cycle pulse on a malformed frame.
- `frame_count`  out  16  count of completed frames. Wraps.

## Operation
- Buffer: 2 entries. Each entry holds {data, sop, eop, freq, use}, with an occupancy count of 0..2.
- Push when `valid_in && ready_out` and the FSM keeps the beat. Pop when `valid_out && ready_in`.
- Simultaneous push and pop leave the count unchanged. Order is FIFO.
- `ready_out` = (count < 2) computed for the next cycle, i.e. registered.
- A push while count==2 is impossible by construction. Verify it never happens.
- Outputs: `valid_out` = (count != 0). `data_out`, `sop_out`, `eop_out`, `freq_flag_out` and `use_flag_out` come from the head entry.
- When the buffer is empty, the flag outputs hold the last head value. `data_out`, `sop_out` and `eop_out` are 0.
- Flag latch: on an accepted beat with `sop_in`=1, capture `freq_flag_in`/`use_flag_in` into the latch register. That beat and every later beat of the frame store the captured values. Flag changes mid-frame have no effect on output.
- FSM states are IDLE and IN_FRAME. The pixel counter is 17 bits, and counter values include the current beat.
- IDLE:
  - Accepted beat with sop=0 is consumed and dropped: not pushed, no error.
  - Accepted beat with sop=1 is pushed and sets counter=1.
  - If eop is also 1 on that beat: close the frame (length 1), then stay IDLE. Otherwise go to IN_FRAME.
- IN_FRAME:
  - Accepted beat with sop=0, eop=0: pushed, counter+1.
  - Accepted beat with eop=1, sop=0: pushed. Frame length = counter+1. If length != `IMG_W*IMG_H`, pulse `frame_error`. Increment `frame_count`. Go to IDLE.
  - Accepted beat with sop=1: pulse `frame_error`. The beat is pushed as a new frame, counter=1, and the flag latch updates. Apply the eop rules above if eop is also set.
- `frame_error` is registered, asserted the cycle after the offending handshake.

## Timing
- Latency: a beat accepted at edge N is on the outputs with `valid_out`=1 after edge N.
- Throughput: 1 beat/cycle with `ready_in` held high.
- Backpressure: `ready_in` low for 2+ cycles drops `ready_out` once 2 entries are held. `ready_out` returns the cycle after the first pop.
- Output stability: while `valid_out`=1 and `ready_in`=0, every source output holds.
- Reset values: count=0, `valid_out`=0, `ready_out`=0, `data_out`/`sop_out`/`eop_out`=0, flag outputs=0, latch=0, `frame_error`=0, `frame_count`=0, state IDLE, counter 0.
  - `ready_out` goes to 1 the first cycle after reset deasserts.
- Reset mid-frame flushes buffered beats with no error pulse. The next frame must begin with sop.

## Test plan
- Reset, then one 76800-beat frame with `ready_in`=1 and `freq_flag_in`=2 at sop -> all beats out 1 cycle later in order, `freq_flag_out`=2 throughout, `frame_count`=1, no `frame_error`.
- `freq_flag_in` changes 2->3 mid-frame -> output stays 2 until the next frame's sop beat, which carries 3.
- Stream 0x001, 0x002, 0x003 with `ready_in` low 3 cycles -> `ready_out` low after 2 beats. 0x001 is held stable, then 0x001, 0x002, 0x003 follow with no loss or duplication.
- Three beats with sop=0 before any sop -> none appear at output, no error. The following sop frame passes normally.
- Frame with eop at beat 100 (IMG_W=10, IMG_H=10 gives an exact match, then rerun with eop at beat 99) -> exact: no error. Short: `frame_error` pulses once, `frame_count` increments in both runs.
- Two sops without eop -> `frame_error` pulse, the second frame passes. Assert `reset` with 2 beats buffered -> `valid_out`=0 next cycle, `frame_count`=0.
